// File: rtl/code_input_debouncer.sv
// Two-flop synchroniser plus IDLE/CHECK debouncer for the code path, with a one-cycle strobe per accepted code.
// Optional auto-repeat strobes while a non-zero code is held: define CODE_AUTOREPEAT_EN.
module code_input_debouncer #(
   parameter int unsigned CODE_W          = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned REPEAT_DELAY    = 1000,
   parameter int unsigned REPEAT_PERIOD   = 250
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CODE_W-1:0] sw_in,
   output logic [CODE_W-1:0] code_out,
   output logic              code_strobe,
   output logic              busy,
   output logic [7:0]        glitch_cnt
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
      $error("code_input_debouncer: parameter out of range");
   end

   typedef enum logic {IDLE, CHECK} state_t;

   state_t             state, state_nx;
   logic [CODE_W-1:0]  sync1, sync2;
   logic [CODE_W-1:0]  cand, cand_nx, code_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic [7:0]         glitch_nx;
   logic               accept;
   logic               rep_fire;

   always_comb begin
      state_nx  = state;
      cand_nx   = cand;
      cnt_nx    = cnt;
      code_nx   = code_out;
      glitch_nx = glitch_cnt;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (sync2 != code_out) begin
               cand_nx  = sync2;
               cnt_nx   = '0;
               state_nx = CHECK;
            end
         end
         CHECK: begin
            if (sync2 != cand) begin
               if (glitch_cnt != 8'hFF) glitch_nx = glitch_cnt + 8'd1;
               if (sync2 == code_out) begin
                  state_nx = IDLE;
               end else begin
                  cand_nx = sync2;
                  cnt_nx  = '0;
               end
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               code_nx  = cand;
               accept   = 1'b1;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

`ifdef CODE_AUTOREPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

   logic [REP_W-1:0] rep, rep_nx;
   logic             rep_first, rep_first_nx;

   // rep_first distinguishes the initial delay from the steady repeat period
   always_comb begin
      rep_nx       = '0;
      rep_first_nx = 1'b0;
      rep_fire     = 1'b0;
      if (state == IDLE && code_out != '0 && sync2 == code_out) begin
         if (!rep_first && rep == REP_W'(REPEAT_DELAY - 1)) begin
            rep_fire     = 1'b1;
            rep_first_nx = 1'b1;
         end else if (rep_first && rep == REP_W'(REPEAT_PERIOD - 1)) begin
            rep_fire     = 1'b1;
            rep_first_nx = 1'b1;
         end else begin
            rep_nx       = rep + REP_W'(1);
            rep_first_nx = rep_first;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rep       <= '0;
         rep_first <= 1'b0;
      end else begin
         rep       <= rep_nx;
         rep_first <= rep_first_nx;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1       <= '0;
         sync2       <= '0;
         state       <= IDLE;
         cand        <= '0;
         cnt         <= '0;
         code_out    <= '0;
         glitch_cnt  <= '0;
         code_strobe <= 1'b0;
      end else begin
         sync1       <= sw_in;
         sync2       <= sync1;
         state       <= state_nx;
         cand        <= cand_nx;
         cnt         <= cnt_nx;
         code_out    <= code_nx;
         glitch_cnt  <= glitch_nx;
         code_strobe <= accept | rep_fire;
      end
   end

   assign busy = (state == CHECK);

endmodule

// File: tb/tb_code_input_debouncer.sv
// Scoreboard bench for code_input_debouncer: run-length reference model pushes expected strobes, a negedge monitor checks them.
// Build with CODE_AUTOREPEAT_EN defined to also model auto-repeat strobes.
module tb_code_input_debouncer;

   localparam int unsigned D  = 4;
   localparam int unsigned RD = 8;
   localparam int unsigned RP = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sw_in;
   logic [3:0] code_out;
   logic       code_strobe;
   logic       busy;
   logic [7:0] glitch_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   code_input_debouncer #(
      .CODE_W(4),
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sw_in(sw_in),
      .code_out(code_out),
      .code_strobe(code_strobe),
      .busy(busy),
      .glitch_cnt(glitch_cnt)
   );

   always #5 clk = ~clk;

   // Reference: inputs reach the debouncer two clocks late; a value that differs from
   // the accepted code is accepted once it has been seen on D+1 consecutive edges.
   logic [3:0] dq[$];
   logic [3:0] exp_q[$];
   logic [3:0] rv, mc;
   int         rl, mg, age;
   bit         started = 0;

   always @(posedge clk) begin
      logic [3:0] s, prev_mc;
      bit         was_idle;
      started = 1;
      if (rst) begin
         dq = '{4'h0, 4'h0};
         rv = 4'h0; mc = 4'h0; rl = 0; mg = 0; age = 0;
      end else begin
         s = dq.pop_front();
         dq.push_back(sw_in);
         was_idle = (rv == mc);
         prev_mc  = mc;
         if (s == rv) begin
            rl++;
         end else begin
            if (rv != mc && mg < 255) mg++;
            rv = s;
            rl = 1;
         end
         if (rv != mc && rl == D + 1) begin
            mc = rv;
            exp_q.push_back(rv);
         end
`ifdef CODE_AUTOREPEAT_EN
         if (was_idle && s == prev_mc && prev_mc != 4'h0) begin
            age++;
            if (age == RD || (age > RD && (age - RD) % RP == 0)) exp_q.push_back(prev_mc);
         end else begin
            age = 0;
         end
`else
         if (was_idle && s == prev_mc) age = 0;
`endif
      end
   end

   always @(negedge clk) begin
      if (started) begin
         if (code_strobe) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_strobe: got strobe code=%h, required no strobe (t=%0t)", code_out, $time);
            end else begin
               logic [3:0] e;
               e = exp_q.pop_front();
               if (code_out !== e) begin
                  n_bad++;
                  $display("FAIL strobe_code: got %h, required %h (t=%0t)", code_out, e, $time);
               end
            end
         end else if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_strobe: got no strobe, required strobe code=%h (t=%0t)", exp_q[0], $time);
            exp_q.delete();
         end
         n_cmp++;
         if (code_out !== mc) begin
            n_bad++;
            $display("FAIL code_out: got %h, required %h (t=%0t)", code_out, mc, $time);
         end
         n_cmp++;
         if (busy !== (rv != mc)) begin
            n_bad++;
            $display("FAIL busy: got %b, required %b (t=%0t)", busy, (rv != mc), $time);
         end
         n_cmp++;
         if (glitch_cnt !== 8'(mg)) begin
            n_bad++;
            $display("FAIL glitch_cnt: got %0d, required %0d (t=%0t)", glitch_cnt, mg, $time);
         end
      end
   end

   task automatic hold(input logic [3:0] v, input int n);
      sw_in = v;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      rst   = 1'b1;
      sw_in = 4'hF;
      repeat (3) begin
         @(posedge clk);
         #2;
      end
      rst = 1'b0;
      hold(4'hF, 12);
      // clean change, short pulse, bounce then settle
      hold(4'h0, 12);
      hold(4'h5, 12);
      hold(4'h0, 12);
      hold(4'h3, 2);
      hold(4'h0, 12);
      hold(4'h5, 12);
      hold(4'h7, 1);
      hold(4'h5, 1);
      hold(4'h7, 1);
      hold(4'h7, 12);
      hold(4'h0, 12);
      for (int i = 0; i < 300; i++) begin
         hold(4'h3, 2);
         hold(4'h0, 2);
      end
      hold(4'h0, 6);
      // reset while a candidate is being qualified
      hold(4'h9, 4);
      rst = 1'b1;
      hold(4'h9, 2);
      rst = 1'b0;
      hold(4'h9, 12);
      // held code for auto-repeat, then release to zero
      hold(4'h6, 30);
      hold(4'h0, 30);
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1;
            hold(4'($urandom_range(0, 15)), $urandom_range(1, 3));
            rst = 1'b0;
         end
         hold(4'($urandom_range(0, 15)), $urandom_range(1, D + 6));
      end
      hold(sw_in, 40);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
